// File: rtl/mem_stage_pipe.sv
// Memory stage of the vector ASIP pipeline: EX/MEM register, byte-addressed data
// memory with scalar and lane-serial vector access, and the MEM/WB register.
module mem_stage_pipe #(
  parameter int N     = 32,
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int A     = 32,
  parameter int DEPTH = 4096
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           enable_i,
  input  logic [N-1:0]   RD1_S_i,
  input  logic [N-1:0]   RD2_S_i,
  input  logic [N-1:0]   AluResult_S_i,
  input  logic           RegFile_WE_i,
  input  logic           MemWE_i,
  input  logic           WBSelect_i,
  input  logic           OpSource_i,
  input  logic [3:0]     A3_i,
  input  logic [1:0]     OpType_i,
  input  logic [V*L-1:0] RD1_V_i,
  input  logic [V*L-1:0] RD2_V_i,
  input  logic [V*L-1:0] AluResult_V_i,
  output logic [N-1:0]   Data_Mem_S_o,
  output logic [N-1:0]   Data_Result_S_o,
  output logic [V*L-1:0] Data_Mem_V_o,
  output logic [V*L-1:0] Data_Result_V_o,
  output logic           RegFile_WE_o,
  output logic           WBSelect_o,
  output logic [3:0]     A3_o,
  output logic [1:0]     OpType_o,
  output logic [L-1:0]   mem_data_o,
  output logic           mem_ready_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int KW = $clog2(V);
  localparam int VW = V * L;

  // state | meaning
  // IDLE  | scalar op (or nothing) in MEM; vector op here only right after a stall edge case
  // VEC   | vector op accessing lane k_q, pipeline stalled
  // DONE  | all lanes done, vector load data presented to MEM/WB
  typedef enum logic [1:0] {IDLE, VEC, DONE} state_t;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [VW-1:0] vbuf_q;
  logic [L-1:0]  last_q;
  logic [L-1:0]  mem [DEPTH];

  logic [N-1:0]  rd1_s_q, rd2_s_q, alu_s_q;
  logic          rf_we_q, mem_we_q, wbsel_q, opsrc_q;
  logic [3:0]    a3_q;
  logic [1:0]    optype_q;
  logic [VW-1:0] rd1_v_q, rd2_v_q, alu_v_q;

  logic          adv, vec_q;
  logic [A-1:0]  addr_a;
  logic [IW-1:0] idx, lane_idx;
  logic [L-1:0]  store_s, store_lane, rd_s, rd_lane, mem_data;
  logic [VW-1:0] store_v, data_mem_v;
  logic [N-1:0]  data_mem_s;
  logic          unused_bits;

  assign vec_q       = optype_q[1];
  assign mem_ready_o = (state_q == DONE) || ((state_q == IDLE) && !vec_q);
  assign adv         = enable_i && mem_ready_o;

  assign addr_a     = rd1_s_q[A-1:0];
  assign idx        = addr_a[IW-1:0];
  assign lane_idx   = idx + IW'(k_q);
  assign store_s    = opsrc_q ? alu_s_q[L-1:0] : rd2_s_q[L-1:0];
  assign store_v    = opsrc_q ? alu_v_q : rd2_v_q;
  assign store_lane = store_v[k_q*L +: L];
  assign rd_s       = mem[idx];
  assign rd_lane    = mem[lane_idx];
  assign unused_bits = ^{rd1_v_q, addr_a[A-1:IW], rd2_s_q[N-1:L]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd1_s_q  <= '0;
      rd2_s_q  <= '0;
      alu_s_q  <= '0;
      rf_we_q  <= 1'b0;
      mem_we_q <= 1'b0;
      wbsel_q  <= 1'b0;
      opsrc_q  <= 1'b0;
      a3_q     <= '0;
      optype_q <= '0;
      rd1_v_q  <= '0;
      rd2_v_q  <= '0;
      alu_v_q  <= '0;
    end else if (adv) begin
      rd1_s_q  <= RD1_S_i;
      rd2_s_q  <= RD2_S_i;
      alu_s_q  <= AluResult_S_i;
      rf_we_q  <= RegFile_WE_i;
      mem_we_q <= MemWE_i;
      wbsel_q  <= WBSelect_i;
      opsrc_q  <= OpSource_i;
      a3_q     <= A3_i;
      optype_q <= OpType_i;
      rd1_v_q  <= RD1_V_i;
      rd2_v_q  <= RD2_V_i;
      alu_v_q  <= AluResult_V_i;
    end
  end

  // A vector op arriving on an advance edge goes straight to VEC so that the
  // stall lasts exactly V cycles; the IDLE-with-vector path is only a fallback.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mem_data = mem_we_q ? store_s : rd_s;
    case (state_q)
      IDLE: begin
        if ((adv && OpType_i[1]) || (enable_i && vec_q)) begin
          state_d = VEC;
          k_d     = '0;
        end
      end
      VEC: begin
        mem_data = mem_we_q ? store_lane : rd_lane;
        if (enable_i) begin
          if (k_q == KW'(V - 1)) begin
            state_d = DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      DONE: begin
        mem_data = last_q;
        if (adv) begin
          state_d = OpType_i[1] ? VEC : IDLE;
          k_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      k_q     <= '0;
      vbuf_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if ((state_q == VEC) && enable_i) begin
        vbuf_q[k_q*L +: L] <= rd_lane;
        last_q             <= mem_data;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge CLK) begin
    if ((state_q == IDLE) && adv && mem_we_q && !vec_q)
      mem[idx] <= store_s;
    else if ((state_q == VEC) && enable_i && mem_we_q)
      mem[lane_idx] <= store_lane;
  end

  assign mem_data_o = mem_data;
  assign data_mem_s = vec_q ? '0 : {{(N-L){1'b0}}, rd_s};
  assign data_mem_v = (state_q == DONE) ? vbuf_q : '0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Data_Mem_S_o    <= '0;
      Data_Result_S_o <= '0;
      Data_Mem_V_o    <= '0;
      Data_Result_V_o <= '0;
      RegFile_WE_o    <= 1'b0;
      WBSelect_o      <= 1'b0;
      A3_o            <= '0;
      OpType_o        <= '0;
    end else if (adv) begin
      Data_Mem_S_o    <= data_mem_s;
      Data_Result_S_o <= alu_s_q;
      Data_Mem_V_o    <= data_mem_v;
      Data_Result_V_o <= alu_v_q;
      RegFile_WE_o    <= rf_we_q;
      WBSelect_o      <= wbsel_q;
      A3_o            <= a3_q;
      OpType_o        <= optype_q;
    end
  end
endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed and random scalar/vector ops checked
// against a byte-array memory model and transaction-level pipeline expectations.
module tb_mem_stage_pipe;
  localparam int V     = 20;
  localparam int DEPTH = 4096;

  logic         CLK = 1'b0;
  logic         RST;
  logic         enable_i;
  logic [31:0]  RD1_S_i, RD2_S_i, AluResult_S_i;
  logic         RegFile_WE_i, MemWE_i, WBSelect_i, OpSource_i;
  logic [3:0]   A3_i;
  logic [1:0]   OpType_i;
  logic [159:0] RD1_V_i, RD2_V_i, AluResult_V_i;
  logic [31:0]  Data_Mem_S_o, Data_Result_S_o;
  logic [159:0] Data_Mem_V_o, Data_Result_V_o;
  logic         RegFile_WE_o, WBSelect_o;
  logic [3:0]   A3_o;
  logic [1:0]   OpType_o;
  logic [7:0]   mem_data_o;
  logic         mem_ready_o;

  mem_stage_pipe dut (
    .CLK(CLK), .RST(RST), .enable_i(enable_i),
    .RD1_S_i(RD1_S_i), .RD2_S_i(RD2_S_i), .AluResult_S_i(AluResult_S_i),
    .RegFile_WE_i(RegFile_WE_i), .MemWE_i(MemWE_i), .WBSelect_i(WBSelect_i),
    .OpSource_i(OpSource_i), .A3_i(A3_i), .OpType_i(OpType_i),
    .RD1_V_i(RD1_V_i), .RD2_V_i(RD2_V_i), .AluResult_V_i(AluResult_V_i),
    .Data_Mem_S_o(Data_Mem_S_o), .Data_Result_S_o(Data_Result_S_o),
    .Data_Mem_V_o(Data_Mem_V_o), .Data_Result_V_o(Data_Result_V_o),
    .RegFile_WE_o(RegFile_WE_o), .WBSelect_o(WBSelect_o), .A3_o(A3_o),
    .OpType_o(OpType_o), .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o)
  );

  always #5 CLK = ~CLK;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] ref_mem [DEPTH];
  bit         known   [DEPTH];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] r160();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic bubble();
    RD1_S_i = '0; RD2_S_i = '0; AluResult_S_i = '0;
    RegFile_WE_i = 0; MemWE_i = 0; WBSelect_i = 0; OpSource_i = 0;
    A3_i = '0; OpType_i = '0; RD1_V_i = '0; RD2_V_i = '0; AluResult_V_i = '0;
  endtask

  task automatic drive(input bit vec, we, src, input logic [31:0] addr, rd2s, alus,
                       input logic [159:0] rd2v, aluv, input logic [3:0] a3,
                       input bit rfwe, wbsel, ot0);
    RD1_S_i = addr; RD2_S_i = rd2s; AluResult_S_i = alus;
    RegFile_WE_i = rfwe; MemWE_i = we; WBSelect_i = wbsel; OpSource_i = src;
    A3_i = a3; OpType_i = {vec, ot0}; RD1_V_i = r160(); RD2_V_i = rd2v; AluResult_V_i = aluv;
  endtask

  // Model update for a vector op: reads see pre-write contents, lanes wrap mod DEPTH.
  task automatic model_vec(input logic [31:0] addr, input bit we, src, input logic [159:0] rd2v,
                           aluv, input int nlanes, output logic [159:0] exp_v,
                           output logic [159:0] mask);
    int a;
    exp_v = '0; mask = '0;
    for (int k = 0; k < V; k++) begin
      a = (int'(addr % DEPTH) + k) % DEPTH;
      exp_v[k*8 +: 8] = ref_mem[a];
      if (known[a]) mask[k*8 +: 8] = 8'hFF;
      if (we && k < nlanes) begin
        ref_mem[a] = src ? aluv[k*8 +: 8] : rd2v[k*8 +: 8];
        known[a]   = 1;
      end
    end
  endtask

  // Caller is at a negedge. Issues one op, then a bubble, and checks the WB outputs.
  task automatic do_op(input bit vec, we, src, input logic [31:0] addr, rd2s, alus,
                       input logic [159:0] rd2v, aluv, input logic [3:0] a3,
                       input bit rfwe, wbsel, ot0);
    int idx, cnt;
    logic [7:0] exp_s, exp_md;
    bit ks, kmd;
    logic [159:0] exp_v, mask;
    idx = int'(addr % DEPTH);
    exp_s = ref_mem[idx]; ks = known[idx];
    exp_md = exp_s; kmd = ks;
    drive(vec, we, src, addr, rd2s, alus, rd2v, aluv, a3, rfwe, wbsel, ot0);
    if (vec) model_vec(addr, we, src, rd2v, aluv, V, exp_v, mask);
    else if (we) begin
      exp_md = src ? alus[7:0] : rd2s[7:0]; kmd = 1;
      ref_mem[idx] = exp_md; known[idx] = 1;
    end
    @(posedge CLK); @(negedge CLK);
    bubble();
    if (!vec) begin
      chk("ready_scalar", mem_ready_o, 1);
      if (kmd) chk("mem_data_scalar", mem_data_o, exp_md);
    end else begin
      cnt = 0;
      while (mem_ready_o !== 1'b1 && cnt < 200) begin cnt++; @(negedge CLK); end
      chk("ready_low_cycles", cnt, V);
    end
    @(posedge CLK); @(negedge CLK);
    chk("wb_result_s", Data_Result_S_o, alus);
    chk("wb_result_v", Data_Result_V_o, aluv);
    chk("wb_ctrl", {RegFile_WE_o, WBSelect_o, A3_o, OpType_o}, {rfwe, wbsel, a3, vec, ot0});
    if (!vec) begin
      if (ks) chk("wb_mem_s", Data_Mem_S_o, {24'b0, exp_s});
      chk("wb_mem_v_scalar", Data_Mem_V_o, 160'b0);
    end else begin
      chk("wb_mem_v", Data_Mem_V_o & mask, exp_v & mask);
    end
  endtask

  initial begin
    logic [159:0] v, ev, mk;
    logic [31:0] base;
    int cnt;
    RST = 0; enable_i = 1; bubble();
    @(negedge CLK); @(negedge CLK);
    chk("rst_wb", {Data_Mem_S_o, Data_Result_S_o, Data_Mem_V_o, Data_Result_V_o}, '0);
    chk("rst_ctrl", {RegFile_WE_o, WBSelect_o, A3_o, OpType_o}, '0);
    chk("rst_ready", mem_ready_o, 1);
    RST = 1;
    @(negedge CLK);

    for (int k = 0; k < 16; k++)
      do_op(0, 1, 0, 32'h10000 + k, k, $urandom, '0, r160(), 4'(k), 0, 0, 0);
    for (int k = 0; k < 16; k++)
      do_op(0, 0, 0, 32'h10000 + k, 0, $urandom, '0, r160(), 4'(k), 1, 1, 0);

    for (int j = 0; j < V; j++) v[j*8 +: 8] = 8'(j + 1);
    do_op(1, 1, 0, 32'h10000, 0, 32'h1234, v, r160(), 4'h3, 0, 0, 0);
    do_op(1, 0, 0, 32'h10000, 0, 32'h5678, '0, r160(), 4'h4, 1, 1, 1);
    chk("vec_lanes_direct", Data_Mem_V_o, v);

    do_op(0, 1, 1, 32'h20, 32'h11, 32'hA5, '0, '0, 4'h1, 0, 0, 0);
    do_op(0, 0, 0, 32'h20, 0, 32'h0, '0, '0, 4'h1, 1, 1, 0);
    chk("opsource_alu", Data_Mem_S_o, 32'hA5);

    v = r160();
    do_op(1, 1, 0, DEPTH - 3, 0, $urandom, v, r160(), 4'h5, 0, 0, 0);
    do_op(1, 0, 0, DEPTH - 3, 0, $urandom, '0, r160(), 4'h6, 1, 0, 0);
    do_op(0, 0, 0, 32'h0, 0, $urandom, '0, r160(), 4'h7, 1, 0, 0);
    chk("wrap_idx0", Data_Mem_S_o, {24'b0, v[3*8 +: 8]});

    for (int i = 0; i < 40; i++)
      do_op($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom & 32'hFFFF_F000) | $urandom_range(0, 255), $urandom, $urandom,
            r160(), r160(), 4'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1));

    // Stall mid-VEC: k and mem_data_o must freeze while enable_i is low.
    v = r160();
    drive(1, 1, 0, 32'h300, 0, $urandom, v, r160(), 4'h8, 0, 0, 0);
    model_vec(32'h300, 1, 0, v, '0, V, ev, mk);
    @(posedge CLK); @(negedge CLK);
    bubble();
    for (int i = 0; i < 4; i++) begin chk("stall_pre_ready", mem_ready_o, 0); @(negedge CLK); end
    enable_i = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_mem_data", mem_data_o, v[4*8 +: 8]);
      chk("stall_ready", mem_ready_o, 0);
    end
    enable_i = 1;
    cnt = 0;
    while (mem_ready_o !== 1'b1 && cnt < 200) begin cnt++; @(negedge CLK); end
    chk("stall_remaining", cnt, V - 4);
    @(posedge CLK); @(negedge CLK);
    do_op(1, 0, 0, 32'h300, 0, 32'hCAFE, '0, r160(), 4'h9, 1, 1, 0);
    chk("stall_readback", Data_Mem_V_o, v);

    // Reset mid-VEC after five lanes have been stored.
    v = r160();
    base = 32'h400;
    drive(1, 1, 0, base, 0, $urandom, v, r160(), 4'hA, 1, 0, 0);
    model_vec(base, 1, 0, v, '0, 5, ev, mk);
    @(posedge CLK); @(negedge CLK);
    bubble();
    for (int i = 0; i < 5; i++) @(negedge CLK);
    RST = 0;
    #1;
    chk("midrst_wb", {Data_Mem_S_o, Data_Result_S_o, Data_Mem_V_o, Data_Result_V_o}, '0);
    chk("midrst_ctrl", {RegFile_WE_o, WBSelect_o, A3_o, OpType_o}, '0);
    chk("midrst_ready", mem_ready_o, 1);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    for (int j = 0; j < 5; j++) begin
      do_op(0, 0, 0, base + j, 0, $urandom, '0, r160(), 4'hB, 1, 1, 0);
      chk("midrst_kept", Data_Mem_S_o[7:0], v[j*8 +: 8]);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mem_stage_pipe.md
# mem_stage_pipe

Memory stage of the vector ASIP pipeline. It contains the EX/MEM pipeline register, a byte-addressed data memory with scalar and vector load/store access, and the MEM/WB pipeline register. Scalar accesses complete in one cycle. Vector accesses run one lane per cycle and stall both pipeline registers until they finish. It sits between the execute stage and register-file write-back.

## Interface
- N, 32, scalar datapath width
- L, 8, byte/lane width
- V, 20, vector lanes
- A, 32, address width
- DEPTH, 4096, data memory size in bytes (power of two)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  reset, asynchronous, active-low
- enable_i  in  1  global pipeline enable
- RD1_S_i  in  N  byte address (low A bits used)
- RD2_S_i  in  N  scalar store data (bits [7:0] used)
- AluResult_S_i  in  N  scalar ALU result
- RegFile_WE_i, MemWE_i, WBSelect_i, OpSource_i  in  1 each  write-enable, memory write, WB mux select, store-data source
- A3_i  in  4  destination register
- OpType_i  in  2  bit1 = vector op
- RD1_V_i, RD2_V_i, AluResult_V_i  in  V×L  vector operands and ALU result
- Data_Mem_S_o, Data_Result_S_o  out  N  WB scalar memory data and result
- Data_Mem_V_o, Data_Result_V_o  out  V×L  WB vector memory data and result
- RegFile_WE_o, WBSelect_o  out  1;  A3_o  out  4;  OpType_o  out  2  forwarded controls
- mem_data_o  out  L  byte accessed this cycle (trace)
- mem_ready_o  out  1  MEM stage can advance

## Operation
- Advance condition: adv = enable_i & mem_ready_o.
- EX/MEM register: when adv is high, it captures all *_i inputs. Otherwise it holds.
- MEM/WB register: when adv is high, it captures {Data_Mem_S, Data_Result_S, Data_Mem_V, Data_Result_V, RegFile_WE, WBSelect, A3, OpType} from the MEM stage. Otherwise it holds.
- Index: idx = RD1_S_MEM mod DEPTH. Lane k uses (idx+k) mod DEPTH, so addresses wrap.
- Store data: OpSource=0 selects RD2_S[7:0] or RD2_V. OpSource=1 selects AluResult_S[7:0] or AluResult_V.
- Results: Data_Result_S = AluResult_S_MEM and Data_Result_V = AluResult_V_MEM.
- Scalar op (OpType[1]=0):
  - Data_Mem_S = {zeros, mem[idx]}, read asynchronously (combinationally).
  - Store writes mem[idx] at the clock edge when adv is high and MemWE=1.
  - A read in the same cycle as a write returns the old value.
  - Data_Mem_V = 0.
  - mem_ready_o = 1.
- Vector op (OpType[1]=1), FSM with states IDLE, VEC, DONE and lane counter k:
  - IDLE with a vector op in MEM: mem_ready_o=0, go to VEC with k=0.
  - VEC: each cycle lane k is accessed. buf[k] ← mem[idx+k] (pre-write value). If MemWE=1, mem[idx+k] ← store lane k. Then k increments. After k=V-1, go to DONE.
  - DONE: mem_ready_o=1, Data_Mem_V = buf, then return to IDLE.
  - The FSM and counter freeze while enable_i=0.
- mem_data_o: the store byte in a write cycle, otherwise the read byte of the current access (mem[idx] in IDLE, lane k in VEC). In DONE it repeats the last accessed byte.
- Memory contents are not reset.

## Timing
- Reset (async, active-low) clears:
  - all pipeline registers and outputs to 0;
  - the FSM to IDLE, k to 0 and buf to 0.
- Reset during VEC aborts the operation. Bytes already written stay written.
- Scalar latency: an input captured at edge n appears at the WB outputs after edge n+1.
- Vector latency: the op occupies MEM for V+1 cycles (V access cycles plus DONE). During that time both registers hold and upstream inputs must be held.
- enable_i=0 freezes all state regardless of the FSM.

## Test plan
- Store then load, scalar: for k=0..15, issue MemWE=1 with RD1_S=0x10000+k, RD2_S=k. Then issue loads at the same addresses. Data_Mem_S_o must equal k two edges after each load issue, and mem_ready_o must stay 1 throughout.
- Vector store/load: store RD2_V lanes {j+1} at 0x10000, then do a vector load at that address.
  - mem_ready_o must be low for V cycles per op.
  - After the load reaches WB, Data_Mem_V_o lane j must equal j+1.
- OpSource=1: scalar store with AluResult_S=0xA5 and RD2_S=0x11, then load. The loaded byte must be 0xA5.
- Wrap: vector store at address DEPTH-3. Lanes 3.. must land at indexes 0.. and read back correctly.
- Stall and reset:
  - enable_i=0 mid-VEC must freeze k and the outputs.
  - Asserting RST low mid-VEC must make the WB outputs 0, return the FSM to IDLE and set mem_ready_o to 1 (when no vector op is present). Bytes written before the reset must remain.
